// File: rtl/ee577_pipe_pkg.sv
// Shared definitions for the ID/EX pipeline slice: opcode constants and the
// load-use bubble FSM state type.
package ee577_pipe_pkg;

  localparam logic [4:0] OPC_NOP   = 5'h00;
  localparam logic [4:0] OPC_ADD   = 5'h01;
  localparam logic [4:0] OPC_SUB   = 5'h02;
  localparam logic [4:0] OPC_AND   = 5'h03;
  localparam logic [4:0] OPC_OR    = 5'h04;
  localparam logic [4:0] OPC_LOAD  = 5'h10;
  localparam logic [4:0] OPC_STORE = 5'h11;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } lu_state_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: handshake, decoded fields, operands, forwarding
// controls, registered EX-side copies and the stall counter.
// master = decode/hazard/execute environment, slave = the ID/EX register.
interface id_ex_stage_if #(
  parameter int REG_ADDRESS_LENGTH = 5,
  parameter int OPCODE_LENGTH      = 5,
  parameter int DATA_WIDTH         = 64,
  parameter int CNT_WIDTH          = 16
);

  logic                          id_valid;
  logic                          id_ready;
  logic [OPCODE_LENGTH-1:0]      id_opcode;
  logic [REG_ADDRESS_LENGTH-1:0] id_ra;
  logic [REG_ADDRESS_LENGTH-1:0] id_rb;
  logic [REG_ADDRESS_LENGTH-1:0] id_rd;
  logic                          id_rd_we;
  logic [DATA_WIDTH-1:0]         id_ra_data;
  logic [DATA_WIDTH-1:0]         id_rb_data;
  logic                          fwd_sel_ra;
  logic                          fwd_sel_rb;
  logic [DATA_WIDTH-1:0]         ex_result;
  logic                          flush;
  logic                          ex_ready;
  logic                          ex_valid;
  logic [OPCODE_LENGTH-1:0]      ex_opcode;
  logic [REG_ADDRESS_LENGTH-1:0] ex_rd;
  logic                          ex_rd_we;
  logic [DATA_WIDTH-1:0]         ex_ra_data;
  logic [DATA_WIDTH-1:0]         ex_rb_data;
  logic [REG_ADDRESS_LENGTH-1:0] lasttime_rd;
  logic                          lasttime_rd_valid;
  logic [CNT_WIDTH-1:0]          stall_cnt;

  modport master (
    output id_valid, id_opcode, id_ra, id_rb, id_rd, id_rd_we,
           id_ra_data, id_rb_data, fwd_sel_ra, fwd_sel_rb,
           ex_result, flush, ex_ready,
    input  id_ready, ex_valid, ex_opcode, ex_rd, ex_rd_we,
           ex_ra_data, ex_rb_data, lasttime_rd, lasttime_rd_valid, stall_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_ra, id_rb, id_rd, id_rd_we,
           id_ra_data, id_rb_data, fwd_sel_ra, fwd_sel_rb,
           ex_result, flush, ex_ready,
    output id_ready, ex_valid, ex_opcode, ex_rd, ex_rd_we,
           ex_ra_data, ex_rb_data, lasttime_rd, lasttime_rd_valid, stall_cnt
  );

endinterface

// File: rtl/operand_fwd_mux.sv
// One operand's bypass path: the hazard unit only matches addresses, so the
// select is qualified with a live, register-writing EX instruction before the
// EX result may replace the register-file value.
module operand_fwd_mux #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  fwd_sel,
  input  logic                  ex_valid,
  input  logic                  ex_rd_we,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic [DATA_WIDTH-1:0] rf_data,
  output logic [DATA_WIDTH-1:0] operand
);

  logic fwd_en;

  assign fwd_en  = fwd_sel & ex_valid & ex_rd_we;
  assign operand = fwd_en ? ex_result : rf_data;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready capture, EX-result bypass into
// both operands, flush, a saturating stall counter and the EX-resident RD
// exported to the hazard unit.
// Optional: define LOAD_USE_STALL_EN to build the load-use bubble FSM
// (RUN/BUBBLE) that inserts one bubble between a load and its consumer.
module id_ex_stage
  import ee577_pipe_pkg::*;
#(
  parameter int                     REG_ADDRESS_LENGTH = 5,
  parameter int                     OPCODE_LENGTH      = 5,
  parameter int                     DATA_WIDTH         = 64,
  parameter logic [OPCODE_LENGTH-1:0] LOAD_OPCODE      = OPC_LOAD,
  parameter int                     CNT_WIDTH          = 16
) (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);

  logic                          vld_p1;
  logic [OPCODE_LENGTH-1:0]      opcode_p1;
  logic [REG_ADDRESS_LENGTH-1:0] rd_p1;
  logic                          rd_we_p1;
  logic [DATA_WIDTH-1:0]         ra_data_p1;
  logic [DATA_WIDTH-1:0]         rb_data_p1;
  logic [CNT_WIDTH-1:0]          stall_cnt_r;

  logic                          lu_hold;
  logic                          id_ready;
  logic                          capture;
  logic                          stall;
  logic [DATA_WIDTH-1:0]         ra_data_p0;
  logic [DATA_WIDTH-1:0]         rb_data_p0;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // A flush frees the stage this cycle; the offered instruction is dropped.
  assign id_ready = bus.flush | ((~vld_p1 | bus.ex_ready) & ~lu_hold);
  assign capture  = bus.id_valid & id_ready & ~bus.flush;
  assign stall    = bus.id_valid & ~id_ready;

  // ---- stage p0: operand selection ahead of the ID/EX register ----
  operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_a (
    .fwd_sel   (bus.fwd_sel_ra),
    .ex_valid  (vld_p1),
    .ex_rd_we  (rd_we_p1),
    .ex_result (bus.ex_result),
    .rf_data   (bus.id_ra_data),
    .operand   (ra_data_p0)
  );

  operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_b (
    .fwd_sel   (bus.fwd_sel_rb),
    .ex_valid  (vld_p1),
    .ex_rd_we  (rd_we_p1),
    .ex_result (bus.ex_result),
    .rf_data   (bus.id_rb_data),
    .operand   (rb_data_p0)
  );

`ifdef LOAD_USE_STALL_EN
  lu_state_t state;
  lu_state_t state_nxt;
  logic      hit;

  assign hit = bus.id_valid & vld_p1 & rd_we_p1 & (opcode_p1 == LOAD_OPCODE) &
               ((bus.id_ra == rd_p1) | (bus.id_rb == rd_p1));

  // Bubble FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Hold the consumer while the load is in EX; once the load leaves, spend one
  // cycle in BUBBLE so the consumer is captured behind an empty slot.
  always_comb begin
    state_nxt = state;
    lu_hold   = 1'b0;
    case (state)
      RUN: begin
        lu_hold = hit;
        if (hit & bus.ex_ready) state_nxt = BUBBLE;
      end
      BUBBLE:  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    if (bus.flush) state_nxt = RUN;
  end
`else
  logic unused_lu;

  // Without the bubble FSM loads forward like ALU results; these inputs only
  // feed load-use detection.
  assign lu_hold   = 1'b0;
  assign unused_lu = ^{LOAD_OPCODE, bus.id_ra, bus.id_rb};
`endif

  // ---- stage p1: ID/EX control (valid and stall counter) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      stall_cnt_r <= '0;
    end else begin
      if (bus.flush)        vld_p1 <= 1'b0;
      else if (capture)     vld_p1 <= 1'b1;
      else if (bus.ex_ready) vld_p1 <= 1'b0;
      if (stall) stall_cnt_r <= sat_inc(stall_cnt_r);
    end
  end

  // ---- stage p1: ID/EX payload, loaded only on capture ----
  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_p1  <= '0;
      rd_p1      <= '0;
      rd_we_p1   <= 1'b0;
      ra_data_p1 <= '0;
      rb_data_p1 <= '0;
    end else if (capture) begin
      opcode_p1  <= bus.id_opcode;
      rd_p1      <= bus.id_rd;
      rd_we_p1   <= bus.id_rd_we;
      ra_data_p1 <= ra_data_p0;
      rb_data_p1 <= rb_data_p0;
    end
  end

  assign bus.id_ready          = id_ready;
  assign bus.ex_valid          = vld_p1;
  assign bus.ex_opcode         = opcode_p1;
  assign bus.ex_rd             = rd_p1;
  assign bus.ex_rd_we          = rd_we_p1;
  assign bus.ex_ra_data        = ra_data_p1;
  assign bus.ex_rb_data        = rb_data_p1;
  assign bus.lasttime_rd       = rd_p1;
  assign bus.lasttime_rd_valid = vld_p1 & rd_we_p1;
  assign bus.stall_cnt         = stall_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a per-cycle vector table for reset,
// capture, forwarding, stall, flush; hand sequences for counter saturation,
// reset mid-handshake and the load-use pair (expectation depends on
// LOAD_USE_STALL_EN).
module tb_id_ex_stage;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.CNT_WIDTH(CW)) bus ();

  id_ex_stage #(.CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [4:0]  op;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rd;
    logic        we;
    logic [63:0] ra_d;
    logic [63:0] rb_d;
    logic        fa;
    logic        fb;
    logic [63:0] res;
    logic        fl;
    logic        rdy;
    logic        chk_rdy;
    logic        e_rdy;
    logic        e_vld;
    logic [4:0]  e_op;
    logic [4:0]  e_rd;
    logic        e_we;
    logic [63:0] e_ra;
    logic [63:0] e_rb;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [4:0] op, input logic [4:0] ra,
                       input logic [4:0] rb, input logic [4:0] rd, input logic we,
                       input logic [63:0] ra_d, input logic [63:0] rb_d, input logic fa,
                       input logic fb, input logic [63:0] res, input logic fl,
                       input logic rdy);
    bus.id_valid   = vld;
    bus.id_opcode  = op;
    bus.id_ra      = ra;
    bus.id_rb      = rb;
    bus.id_rd      = rd;
    bus.id_rd_we   = we;
    bus.id_ra_data = ra_d;
    bus.id_rb_data = rb_d;
    bus.fwd_sel_ra = fa;
    bus.fwd_sel_rb = fb;
    bus.ex_result  = res;
    bus.flush      = fl;
    bus.ex_ready   = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // field order: rst vld op ra rb rd we ra_d rb_d fa fb res fl rdy |
    //              chk_rdy e_rdy | e_vld e_op e_rd e_we e_ra e_rb e_cnt
    vt[0]  = '{1'b1, 1'b1, 5'h1f, 5'h04, 5'h09, 5'h1e, 1'b1, 64'hFFFF_0000_1234_5678, 64'h0BAD,
               1'b1, 1'b1, 64'hCAFE, 1'b0, 1'b1, 1'b0, 1'b0,
               1'b0, 5'h00, 5'h00, 1'b0, 64'h0, 64'h0, 4'd0};
    vt[1]  = '{1'b1, 1'b1, 5'h10, 5'h07, 5'h07, 5'h07, 1'b1, 64'h55, 64'hAA,
               1'b0, 1'b1, 64'h1, 1'b1, 1'b0, 1'b0, 1'b0,
               1'b0, 5'h00, 5'h00, 1'b0, 64'h0, 64'h0, 4'd0};
    vt[2]  = '{1'b0, 1'b1, 5'h01, 5'h01, 5'h02, 5'h03, 1'b1, 64'hAAAA, 64'hBBBB,
               1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1,
               1'b1, 5'h01, 5'h03, 1'b1, 64'hAAAA, 64'hBBBB, 4'd0};
    vt[3]  = '{1'b0, 1'b1, 5'h02, 5'h03, 5'h04, 5'h05, 1'b1, 64'h1111, 64'h2222,
               1'b1, 1'b0, 64'hDEAD, 1'b0, 1'b1, 1'b1, 1'b1,
               1'b1, 5'h02, 5'h05, 1'b1, 64'hDEAD, 64'h2222, 4'd0};
    vt[4]  = '{1'b0, 1'b1, 5'h03, 5'h01, 5'h01, 5'h03, 1'b0, 64'h5555, 64'h6666,
               1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1,
               1'b1, 5'h03, 5'h03, 1'b0, 64'h5555, 64'h6666, 4'd0};
    vt[5]  = '{1'b0, 1'b1, 5'h04, 5'h03, 5'h03, 5'h06, 1'b1, 64'h1111, 64'h2222,
               1'b1, 1'b1, 64'hDEAD, 1'b0, 1'b1, 1'b1, 1'b1,
               1'b1, 5'h04, 5'h06, 1'b1, 64'h1111, 64'h2222, 4'd0};
    vt[6]  = '{1'b0, 1'b1, 5'h05, 5'h00, 5'h06, 5'h07, 1'b1, 64'h7777, 64'h8888,
               1'b0, 1'b1, 64'hBEEF, 1'b0, 1'b1, 1'b1, 1'b1,
               1'b1, 5'h05, 5'h07, 1'b1, 64'h7777, 64'hBEEF, 4'd0};
    vt[7]  = '{1'b0, 1'b1, 5'h06, 5'h07, 5'h07, 5'h08, 1'b1, 64'h9999, 64'hAAAA,
               1'b1, 1'b1, 64'h1234, 1'b0, 1'b0, 1'b1, 1'b0,
               1'b1, 5'h05, 5'h07, 1'b1, 64'h7777, 64'hBEEF, 4'd1};
    vt[8]  = vt[7];
    vt[8].e_cnt = 4'd2;
    vt[9]  = vt[7];
    vt[9].e_cnt = 4'd3;
    vt[10] = '{1'b0, 1'b0, 5'h06, 5'h07, 5'h07, 5'h08, 1'b1, 64'h9999, 64'hAAAA,
               1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1,
               1'b0, 5'h05, 5'h07, 1'b1, 64'h7777, 64'hBEEF, 4'd3};
    vt[11] = '{1'b0, 1'b1, 5'h06, 5'h07, 5'h07, 5'h08, 1'b1, 64'h9999, 64'hAAAA,
               1'b1, 1'b1, 64'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1,
               1'b1, 5'h06, 5'h08, 1'b1, 64'h9999, 64'hAAAA, 4'd3};
    vt[12] = '{1'b0, 1'b1, 5'h07, 5'h08, 5'h08, 5'h09, 1'b1, 64'h3333, 64'h4444,
               1'b1, 1'b1, 64'h5A5A, 1'b1, 1'b0, 1'b1, 1'b1,
               1'b0, 5'h06, 5'h08, 1'b1, 64'h9999, 64'hAAAA, 4'd3};
    vt[13] = '{1'b0, 1'b0, 5'h07, 5'h08, 5'h08, 5'h09, 1'b1, 64'h3333, 64'h4444,
               1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1,
               1'b0, 5'h06, 5'h08, 1'b1, 64'h9999, 64'hAAAA, 4'd3};

    reset = 1'b1;
    drive(1'b0, 5'h0, 5'h0, 5'h0, 5'h0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      reset = vt[i].rst;
      drive(vt[i].vld, vt[i].op, vt[i].ra, vt[i].rb, vt[i].rd, vt[i].we, vt[i].ra_d,
            vt[i].rb_d, vt[i].fa, vt[i].fb, vt[i].res, vt[i].fl, vt[i].rdy);
      #1;
      if (vt[i].chk_rdy) chk($sformatf("v%0d id_ready", i), 64'(bus.id_ready), 64'(vt[i].e_rdy));
      step();
      chk($sformatf("v%0d ex_valid", i),    64'(bus.ex_valid),   64'(vt[i].e_vld));
      chk($sformatf("v%0d ex_opcode", i),   64'(bus.ex_opcode),  64'(vt[i].e_op));
      chk($sformatf("v%0d ex_rd", i),       64'(bus.ex_rd),      64'(vt[i].e_rd));
      chk($sformatf("v%0d ex_rd_we", i),    64'(bus.ex_rd_we),   64'(vt[i].e_we));
      chk($sformatf("v%0d ex_ra_data", i),  bus.ex_ra_data,      vt[i].e_ra);
      chk($sformatf("v%0d ex_rb_data", i),  bus.ex_rb_data,      vt[i].e_rb);
      chk($sformatf("v%0d stall_cnt", i),   64'(bus.stall_cnt),  64'(vt[i].e_cnt));
      chk($sformatf("v%0d lasttime_rd", i), 64'(bus.lasttime_rd), 64'(vt[i].e_rd));
      chk($sformatf("v%0d lasttime_rd_valid", i), 64'(bus.lasttime_rd_valid),
          64'(vt[i].e_vld & vt[i].e_we));
    end

    // Stall counter saturation: counter is at 3, capture one, then 20 stalls.
    @(negedge clk);
    drive(1'b1, 5'h01, 5'h00, 5'h00, 5'h01, 1'b0, 64'h1, 64'h2, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    step();
    chk("sat capture ex_valid", 64'(bus.ex_valid), 64'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(1'b1, 5'h02, 5'h00, 5'h00, 5'h02, 1'b1, 64'h3, 64'h4, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      #1;
      if (i == 0) chk("sat id_ready", 64'(bus.id_ready), 64'd0);
      step();
      if (i == 4)  chk("sat stall_cnt 8", 64'(bus.stall_cnt), 64'd8);
      if (i == 11) chk("sat stall_cnt reach", 64'(bus.stall_cnt), 64'd15);
      if (i == 19) chk("sat stall_cnt hold", 64'(bus.stall_cnt), 64'd15);
    end
    chk("sat ex_opcode stable", 64'(bus.ex_opcode), 64'h01);

    // Reset mid-handshake: offered instruction is lost, everything clears.
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 5'h02, 5'h01, 5'h01, 5'h04, 1'b1, 64'h77, 64'h88, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
    step();
    chk("rst mid ex_valid",  64'(bus.ex_valid),  64'd0);
    chk("rst mid ex_rd",     64'(bus.ex_rd),     64'd0);
    chk("rst mid ra_data",   bus.ex_ra_data,     64'd0);
    chk("rst mid stall_cnt", 64'(bus.stall_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 5'h0, 5'h0, 5'h0, 5'h0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
    #1;
    chk("rst mid id_ready", 64'(bus.id_ready), 64'd1);

    // Load-use: LOAD rd=7 in EX, consumer reads rb=7 with the hazard select set.
    @(negedge clk);
    drive(1'b1, 5'h10, 5'h00, 5'h00, 5'h07, 1'b1, 64'h1234, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
    step();
    chk("lu load ex_opcode", 64'(bus.ex_opcode), 64'h10);
    @(negedge clk);
    drive(1'b1, 5'h01, 5'h01, 5'h07, 5'h02, 1'b1, 64'h11, 64'h22, 1'b0, 1'b1, 64'h4C4C, 1'b0, 1'b1);
    #1;
`ifdef LOAD_USE_STALL_EN
    chk("lu hold id_ready", 64'(bus.id_ready), 64'd0);
    step();
    chk("lu bubble ex_valid", 64'(bus.ex_valid), 64'd0);
    chk("lu bubble stall_cnt", 64'(bus.stall_cnt), 64'd1);
    @(negedge clk);
    #1;
    chk("lu after id_ready", 64'(bus.id_ready), 64'd1);
    step();
    chk("lu use ex_valid", 64'(bus.ex_valid), 64'd1);
    chk("lu use ex_rd", 64'(bus.ex_rd), 64'd2);
    chk("lu use rb_data", bus.ex_rb_data, 64'h22);
`else
    chk("lu nobubble id_ready", 64'(bus.id_ready), 64'd1);
    step();
    chk("lu use ex_valid", 64'(bus.ex_valid), 64'd1);
    chk("lu use ex_rd", 64'(bus.ex_rd), 64'd2);
    chk("lu use rb_data fwd", bus.ex_rb_data, 64'h4C4C);
    chk("lu stall_cnt", 64'(bus.stall_cnt), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
